// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port round-robin arbiter.
package mem_arb_pkg;

    // Arbiter control states: wait for calibration, pick a winner, hold the command.
    typedef enum logic [1:0] {
        WAIT_RDY = 2'd0,
        IDLE     = 2'd1,
        ISSUE    = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ = 3;

    // Width of a requester ID; never narrower than one bit.
    function automatic int idWidth(input int numReq);
        return (numReq <= 2) ? 1 : $clog2(numReq);
    endfunction

    localparam int ID_W = idWidth(DEF_NUM_REQ);

    // last_gnt starts at the highest index so requester 0 is searched first.
    function automatic int lastGntReset(input int numReq);
        return numReq - 1;
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Tag FIFO holding the requester ID of every accepted read, in issue order.
module mem_arb_tag_fifo #(
    parameter int ID_W  = 2,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic [ID_W-1:0] pushId_i,
    input  logic            pop_i,
    output logic [ID_W-1:0] headId_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ID_W-1:0]  slots_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == FULL_CNT);
    assign headId_o = slots_q[rdPtr_q];
    assign doPop    = pop_i & ~empty_o;
    // A push into a full FIFO is still fine when the head leaves in the same cycle.
    assign doPush   = push_i & (~full_o | doPop);

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            slots_q[wrPtr_q] <= pushId_i;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop keeps the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing one Avalon-style memory port among pixel requesters,
// routing read returns back to their originators through a tag FIFO.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 29,
    parameter int DATA_W  = 32,
    parameter int MAX_RD  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    input  logic                      ram_rdy,
    input  logic                      avl_ready,
    output logic                      avl_write_req,
    output logic                      avl_read_req,
    output logic [ADDR_W-1:0]         avl_addr,
    output logic [DATA_W-1:0]         avl_wdata,
    input  logic                      rd_data_valid,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic                      err
);

    localparam int IdW = idWidth(NUM_REQ);
    localparam logic [IdW-1:0]     LAST_GNT_RST = IdW'(lastGntReset(NUM_REQ));
    localparam logic [NUM_REQ-1:0] ONE_HOT0     = NUM_REQ'(1);

    arb_state_e          state_q;
    logic [IdW-1:0]      gntId_q;
    logic [IdW-1:0]      lastGnt_q;
    logic                writeReq_q;
    logic                readReq_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NUM_REQ-1:0]  rdValid_q;
    logic [DATA_W-1:0]   rdData_q;
    logic                err_q;

    logic [NUM_REQ-1:0]  eligible;
    logic                anyElig_d;
    logic [IdW-1:0]      gntId_d;
    logic                accept;
    logic                fifoPush;
    logic                fifoPop;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [IdW-1:0]      fifoHead;

    // Reads need a free tag slot; writes never wait on the tag FIFO.
    assign eligible = req_valid & (req_wr | {NUM_REQ{~fifoFull}});
    assign accept   = reset & (state_q == ISSUE) & avl_ready;
    assign fifoPush = accept & readReq_q;
    assign fifoPop  = rd_data_valid & ~fifoEmpty;

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        anyElig_d = 1'b0;
        gntId_d   = lastGnt_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!anyElig_d && eligible[(int'(lastGnt_q) + k) % NUM_REQ]) begin
                anyElig_d = 1'b1;
                gntId_d   = IdW'((int'(lastGnt_q) + k) % NUM_REQ);
            end
        end
    end

    // Command FSM: latch the winner in IDLE, hold it stable in ISSUE until accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= WAIT_RDY;
            gntId_q    <= '0;
            lastGnt_q  <= LAST_GNT_RST;
            writeReq_q <= 1'b0;
            readReq_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            unique case (state_q)
                WAIT_RDY: begin
                    if (ram_rdy) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (!ram_rdy) begin
                        state_q <= WAIT_RDY;
                    end else if (anyElig_d) begin
                        state_q    <= ISSUE;
                        gntId_q    <= gntId_d;
                        writeReq_q <= req_wr[gntId_d];
                        readReq_q  <= ~req_wr[gntId_d];
                        addr_q     <= req_addr[int'(gntId_d) * ADDR_W +: ADDR_W];
                        wdata_q    <= req_wdata[int'(gntId_d) * DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    if (avl_ready) begin
                        state_q    <= IDLE;
                        lastGnt_q  <= gntId_q;
                        writeReq_q <= 1'b0;
                        readReq_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= WAIT_RDY;
                end
            endcase
        end
    end

    // Read return path: steer the strobe to the tag at the FIFO head, flag orphan returns.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdValid_q <= '0;
            rdData_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            rdValid_q <= '0;
            if (rd_data_valid) begin
                rdData_q <= mem_rd_data;
                if (fifoEmpty) begin
                    err_q <= 1'b1;
                end else begin
                    rdValid_q <= ONE_HOT0 << fifoHead;
                end
            end
        end
    end

    mem_arb_tag_fifo #(
        .ID_W  (IdW),
        .DEPTH (MAX_RD)
    ) u_tagFifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (fifoPush),
        .pushId_i (gntId_q),
        .pop_i    (fifoPop),
        .headId_o (fifoHead),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    assign req_ack       = accept ? (ONE_HOT0 << gntId_q) : '0;
    assign rd_valid      = rdValid_q;
    assign rd_data       = rdData_q;
    assign avl_write_req = writeReq_q;
    assign avl_read_req  = readReq_q;
    assign avl_addr      = addr_q;
    assign avl_wdata     = wdata_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: requester models, an in-order memory model,
// and expected-command / expected-return queues filled as stimulus is issued.
module tb_mem_port_arb;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 29;
    localparam int DATA_W  = 32;
    localparam int MAX_RD  = 4;

    typedef struct {
        int                id;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ-1:0]        reqValid = '0;
    logic [NUM_REQ-1:0]        reqWr = '0;
    logic [NUM_REQ*ADDR_W-1:0] reqAddr = '0;
    logic [NUM_REQ*DATA_W-1:0] reqWdata = '0;
    logic [NUM_REQ-1:0]        reqAck;
    logic [NUM_REQ-1:0]        rdValid;
    logic [DATA_W-1:0]         rdData;
    logic                      ramRdy = 1'b0;
    logic                      avlReady = 1'b0;
    logic                      avlWriteReq;
    logic                      avlReadReq;
    logic [ADDR_W-1:0]         avlAddr;
    logic [DATA_W-1:0]         avlWdata;
    logic                      rdDataValid = 1'b0;
    logic [DATA_W-1:0]         memRdData = '0;
    logic                      err;

    cmd_t reqQ[$];
    cmd_t expCmd[$];
    rd_t  expRd[$];
    ret_t retQ[$];
    int   acceptCycles[$];
    int   rdCycles[$];

    int   cycle = 0;
    int   retDelay = 10;
    int   lastDue = 0;
    int   acceptCount = 0;
    int   ack2Count = 0;
    int   assertCount = 0;
    int   failCount = 0;
    logic [NUM_REQ-1:0] ackSeen = '0;

    mem_port_arb #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_RD  (MAX_RD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (reqValid),
        .req_wr        (reqWr),
        .req_addr      (reqAddr),
        .req_wdata     (reqWdata),
        .req_ack       (reqAck),
        .rd_valid      (rdValid),
        .rd_data       (rdData),
        .ram_rdy       (ramRdy),
        .avl_ready     (avlReady),
        .avl_write_req (avlWriteReq),
        .avl_read_req  (avlReadReq),
        .avl_addr      (avlAddr),
        .avl_wdata     (avlWdata),
        .rd_data_valid (rdDataValid),
        .mem_rd_data   (memRdData),
        .err           (err)
    );

    // Free-running 100 MHz-style clock; only relative cycle timing matters here.
    always #5 clk = ~clk;

    // Data the memory model returns for a given word address.
    function automatic logic [DATA_W-1:0] memData(input logic [ADDR_W-1:0] a);
        return {3'b101, a};
    endfunction

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Advance to just after the next rising edge(s).
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue a requester command and, if it should be accepted, its expected results.
    task automatic applyStimulus(input int id, input logic wr, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input bit expectAccept);
        cmd_t c;
        rd_t  r;
        c.id = id;
        c.wr = wr;
        c.addr = a;
        c.data = d;
        reqQ.push_back(c);
        if (expectAccept) begin
            expCmd.push_back(c);
            if (!wr) begin
                r.id = id;
                r.data = memData(a);
                expRd.push_back(r);
            end
        end
    endtask

    // Bounded wait until the accepted-command count reaches target.
    task automatic waitAccepts(input int target, input int budget);
        int n = 0;
        while (acceptCount < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("acceptWait", 64'(acceptCount), 64'(target));
    endtask

    // Bounded wait until every expected read return has been seen.
    task automatic waitRdDrain(input int budget);
        int n = 0;
        while (expRd.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("rdDrain", 64'(expRd.size()), 64'(0));
    endtask

    // Cycle counter plus in-order memory model driving read returns when they fall due.
    always begin
        @(posedge clk);
        cycle++;
        #1;
        if (retQ.size() > 0 && retQ[0].due <= cycle) begin
            rdDataValid = 1'b1;
            memRdData   = retQ[0].data;
            void'(retQ.pop_front());
        end else begin
            rdDataValid = 1'b0;
            memRdData   = '0;
        end
    end

    // Requester models: each presents its oldest queued command and drops it after an ack.
    always begin
        int  delIdx;
        bit  found;
        @(negedge clk);
        ackSeen = reqAck;
        @(posedge clk);
        #2;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ackSeen[i]) begin
                delIdx = -1;
                for (int j = 0; j < reqQ.size(); j++) begin
                    if (delIdx < 0 && reqQ[j].id == i) delIdx = j;
                end
                if (delIdx >= 0) reqQ.delete(delIdx);
            end
        end
        reqValid = '0;
        reqWr    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            found = 1'b0;
            for (int j = 0; j < reqQ.size(); j++) begin
                if (!found && reqQ[j].id == i) begin
                    found = 1'b1;
                    reqValid[i] = 1'b1;
                    reqWr[i]    = reqQ[j].wr;
                    reqAddr[i*ADDR_W +: ADDR_W]  = reqQ[j].addr;
                    reqWdata[i*DATA_W +: DATA_W] = reqQ[j].data;
                end
            end
        end
    end

    // Monitor: score accepted commands and read returns against the expectation queues.
    always @(negedge clk) begin
        cmd_t e;
        rd_t  r;
        ret_t m;
        if (reset && avlReady && (avlWriteReq || avlReadReq)) begin
            if (expCmd.size() == 0) begin
                checkOutput("cmdUnexpected", 64'(expCmd.size()), 64'(1));
            end else begin
                e = expCmd.pop_front();
                checkOutput("ackId", 64'(reqAck), 64'(1) << e.id);
                checkOutput("cmdWr", 64'(avlWriteReq), 64'(e.wr));
                checkOutput("cmdRd", 64'(avlReadReq), 64'(!e.wr));
                checkOutput("cmdAddr", 64'(avlAddr), 64'(e.addr));
                if (e.wr) checkOutput("cmdData", 64'(avlWdata), 64'(e.data));
            end
            if (reqAck[2]) ack2Count++;
            acceptCount++;
            acceptCycles.push_back(cycle);
            if (avlReadReq) begin
                m.due  = (cycle + retDelay > lastDue) ? cycle + retDelay : lastDue + 1;
                m.data = memData(avlAddr);
                lastDue = m.due;
                retQ.push_back(m);
            end
        end else if (reqAck != '0) begin
            checkOutput("ackIdle", 64'(reqAck), 64'(0));
        end
        if (rdValid != '0) begin
            rdCycles.push_back(cycle);
            if (expRd.size() == 0) begin
                checkOutput("rdSpurious", 64'(rdValid), 64'(0));
            end else begin
                r = expRd.pop_front();
                checkOutput("rdId", 64'(rdValid), 64'(1) << r.id);
                checkOutput("rdData", 64'(rdData), 64'(r.data));
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #60000;
        $display("[TB] FAIL watchdog: run did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset/calibration, round-robin writes, stall, read tagging, errors, reset mid-command.
    initial begin
        int base;
        int relCycle;
        int bRd;
        int n;
        ret_t inj;

        // Reset with memory not ready; a write is already waiting.
        applyStimulus(0, 1'b1, 29'h40, 32'h1111_0000, 1'b1);
        tick(3);
        checkOutput("rstAck", 64'(reqAck), 64'(0));
        checkOutput("rstRdValid", 64'(rdValid), 64'(0));
        checkOutput("rstRdData", 64'(rdData), 64'(0));
        checkOutput("rstWrReq", 64'(avlWriteReq), 64'(0));
        checkOutput("rstRdReq", 64'(avlReadReq), 64'(0));
        checkOutput("rstAddr", 64'(avlAddr), 64'(0));
        checkOutput("rstWdata", 64'(avlWdata), 64'(0));
        checkOutput("rstErr", 64'(err), 64'(0));
        reset = 1'b1;
        tick(4);
        checkOutput("noRdyWr", 64'(avlWriteReq), 64'(0));
        ramRdy = 1'b1;
        tick(1);
        checkOutput("idleWr", 64'(avlWriteReq), 64'(0));
        tick(1);
        checkOutput("issueWr", 64'(avlWriteReq), 64'(1));
        checkOutput("issueAddr", 64'(avlAddr), 64'(29'h40));
        avlReady = 1'b1;
        waitAccepts(1, 10);

        // All three requesters writing: grants 0,1,2,0 every other cycle after reset.
        reset = 1'b0;
        tick(2);
        base = acceptCycles.size();
        applyStimulus(0, 1'b1, 29'h1000, 32'hA000_0000, 1'b1);
        applyStimulus(1, 1'b1, 29'h2000, 32'hA000_0001, 1'b1);
        applyStimulus(2, 1'b1, 29'h3000, 32'hA000_0002, 1'b1);
        applyStimulus(0, 1'b1, 29'h1004, 32'hA000_0003, 1'b1);
        reset = 1'b1;
        relCycle = cycle;
        waitAccepts(acceptCount + 4, 30);
        if (acceptCycles.size() >= base + 4) begin
            checkOutput("rrFirst", 64'(acceptCycles[base] - relCycle), 64'(2));
            for (int k = 1; k < 4; k++) begin
                checkOutput("rrSpacing", 64'(acceptCycles[base+k] - acceptCycles[base]), 64'(2 * k));
            end
        end

        // Read from requester 2 stalled by avl_ready; command must hold steady.
        avlReady = 1'b0;
        base = ack2Count;
        applyStimulus(2, 1'b0, 29'h100, 32'h0, 1'b1);
        n = 0;
        while (!avlReadReq && n < 10) begin
            tick(1);
            n++;
        end
        checkOutput("stallIssue", 64'(avlReadReq), 64'(1));
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checkOutput("holdRd", 64'(avlReadReq), 64'(1));
            checkOutput("holdAddr", 64'(avlAddr), 64'(29'h100));
            checkOutput("holdAck", 64'(reqAck), 64'(0));
        end
        avlReady = 1'b1;
        waitAccepts(acceptCount + 1, 10);
        tick(2);
        checkOutput("ack2Once", 64'(ack2Count - base), 64'(1));
        waitRdDrain(40);

        // Four reads fill the tags; a write slips past while a fifth read waits for a return.
        base = acceptCycles.size();
        bRd  = rdCycles.size();
        applyStimulus(0, 1'b0, 29'h200, 32'h0, 1'b1);
        waitAccepts(acceptCount + 1, 10);
        applyStimulus(2, 1'b0, 29'h210, 32'h0, 1'b1);
        waitAccepts(acceptCount + 1, 10);
        applyStimulus(1, 1'b0, 29'h220, 32'h0, 1'b1);
        waitAccepts(acceptCount + 1, 10);
        applyStimulus(0, 1'b0, 29'h230, 32'h0, 1'b1);
        waitAccepts(acceptCount + 1, 10);
        applyStimulus(1, 1'b1, 29'h240, 32'hCAFE_0001, 1'b1);
        applyStimulus(2, 1'b0, 29'h250, 32'h0, 1'b1);
        waitAccepts(acceptCount + 2, 40);
        waitRdDrain(60);
        if (acceptCycles.size() >= base + 6 && rdCycles.size() >= bRd + 1) begin
            checkOutput("wrBypass", 64'(acceptCycles[base+4] < rdCycles[bRd]), 64'(1));
            checkOutput("rdBlocked", 64'(acceptCycles[base+5] > rdCycles[bRd]), 64'(1));
        end

        // Orphan return with nothing outstanding sets a sticky error.
        checkOutput("errClear", 64'(err), 64'(0));
        inj.due  = cycle;
        inj.data = 32'hDEAD_BEEF;
        retQ.push_back(inj);
        tick(3);
        checkOutput("errSet", 64'(err), 64'(1));
        checkOutput("errNoRd", 64'(rdValid), 64'(0));
        tick(5);
        checkOutput("errHold", 64'(err), 64'(1));

        // Reset while a write is held in ISSUE with two reads outstanding.
        retDelay = 30;
        applyStimulus(0, 1'b0, 29'h300, 32'h0, 1'b1);
        applyStimulus(1, 1'b0, 29'h310, 32'h0, 1'b1);
        waitAccepts(acceptCount + 2, 20);
        avlReady = 1'b0;
        applyStimulus(2, 1'b1, 29'h320, 32'hBEEF_0002, 1'b0);
        n = 0;
        while (!avlWriteReq && n < 10) begin
            tick(1);
            n++;
        end
        checkOutput("t6Issue", 64'(avlWriteReq), 64'(1));
        reset = 1'b0;
        expRd.delete();
        tick(1);
        checkOutput("midRstWr", 64'(avlWriteReq), 64'(0));
        checkOutput("midRstRd", 64'(avlReadReq), 64'(0));
        checkOutput("midRstAddr", 64'(avlAddr), 64'(0));
        checkOutput("midRstErr", 64'(err), 64'(0));
        checkOutput("midRstRdv", 64'(rdValid), 64'(0));
        reset = 1'b1;
        n = 0;
        while (retQ.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        checkOutput("staleDone", 64'(retQ.size()), 64'(0));
        tick(3);
        checkOutput("staleErr", 64'(err), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Round-robin arbiter that shares one Avalon-style port of the 4-port external-memory interface among several pixel requesters: camera 1 write, camera 2 write, HDMI read. Issues one command at a time and holds it until the memory accepts it. Records the requester ID of every accepted read so returned read data goes back to the right requester. Sits between the frame-buffer/capture logic and one `avl_*_N` port of the memory interface, in the 25.2 MHz pixel-clock domain.

## Interface
- `NUM_REQ`, 3: number of requesters (2..4).
- `ADDR_W`, 29: memory word-address width.
- `DATA_W`, 32: data width.
- `MAX_RD`, 4: maximum outstanding reads; tag FIFO depth, power of 2.

- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-low.
- `req_valid`  in  NUM_REQ: per-requester command valid; hold until acked.
- `req_wr`  in  NUM_REQ: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W: packed addresses; requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  NUM_REQ*DATA_W: packed write data.
- `req_ack`  out  NUM_REQ: one-cycle pulse; command accepted by memory.
- `rd_valid`  out  NUM_REQ: one-cycle pulse; `rd_data` belongs to requester i.
- `rd_data`  out  DATA_W: read data, broadcast to all requesters.
- `ram_rdy`  in  1: memory calibrated/ready.
- `avl_ready`  in  1: memory accepts the current command this cycle.
- `avl_write_req`  out  1: write command.
- `avl_read_req`  out  1: read command.
- `avl_addr`  out  ADDR_W: command address.
- `avl_wdata`  out  DATA_W: write data.
- `rd_data_valid`  in  1: memory read return strobe.
- `mem_rd_data`  in  DATA_W: memory read data.
- `err`  out  1: sticky; read return arrived with no outstanding tag.

## Operation
- FSM states:
  - WAIT_RDY: entered at reset. Moves to IDLE once `ram_rdy`=1.
  - IDLE: if `ram_rdy`=0, return to WAIT_RDY. Otherwise, if any requester is eligible, register the winner into `gnt_id` and latch its wr/addr/wdata, then go to ISSUE.
  - ISSUE: drive `avl_write_req` or `avl_read_req`, `avl_addr` and `avl_wdata` from the latched values. On `avl_ready`=1, go to IDLE. Otherwise stay and hold every output stable.
- Eligibility: requester i is eligible when `req_valid[i]`=1 and, for reads only, the tag FIFO is not full. Writes are never blocked by the tag FIFO.
- Arbitration: round-robin. Search starts at `last_gnt+1` mod NUM_REQ; `last_gnt` resets to NUM_REQ-1, so requester 0 has first priority after reset. `last_gnt` updates on acceptance.
- `req_ack[gnt_id]` = (state==ISSUE) & `avl_ready`. This is combinational; the requester may change its inputs on the next cycle.
- On an accepted read, push `gnt_id` into the tag FIFO.
- On `rd_data_valid`=1: pop the FIFO head h, assert `rd_valid[h]` for one cycle, and pass `rd_data` = `mem_rd_data` through registered.
- Push and pop in the same cycle: FIFO occupancy is unchanged.
- `rd_data_valid` with the FIFO empty: no `rd_valid`, and `err` is set until reset.
- `ram_rdy` falls during ISSUE: the command is still held until `avl_ready`. WAIT_RDY is entered only from IDLE.
- Reset mid-command: state goes to WAIT_RDY, the FIFO is flushed and `err` clears. Stale returns after reset set `err`.

## Timing
- Reset values: `req_ack`=0, `rd_valid`=0, `rd_data`=0, `avl_write_req`=0, `avl_read_req`=0, `avl_addr`=0, `avl_wdata`=0, `err`=0.
- Issue latency: `req_valid` seen in IDLE at cycle t puts `avl_*_req` high at t+1. With `avl_ready` high, `req_ack` pulses at t+1.
- Throughput: at most one command every 2 cycles, because IDLE is a bubble state.
- Read return: `rd_valid` and `rd_data` appear one cycle after `rd_data_valid`.
- Return order equals issue order, since the memory returns reads in order.

## Structure
- Package `mem_arb_pkg`: state enum {WAIT_RDY, IDLE, ISSUE}; `ID_W` = clog2(NUM_REQ); reset constant for `last_gnt`.
- Sub-module `mem_arb_tag_fifo`: synchronous FIFO of `ID_W`-bit entries, depth MAX_RD, with push/pop/full/empty and simultaneous push+pop. Round-robin select stays inline.

## Test plan
- Reset with `ram_rdy`=0, then raise `ram_rdy` -> no `avl_*_req` until one cycle after IDLE is reached; all outputs 0 during reset.
- `req_valid`=3'b111, all writes, `avl_ready`=1 -> `req_ack` order 0,1,2,0 on cycles 1,3,5,7; `avl_addr` matches each requester's address.
- Requester 2 read at address 0x100, `avl_ready` low for 3 cycles -> command held unchanged; `req_ack[2]` pulses exactly once, on the cycle `avl_ready`=1.
- 4 reads from requesters 0,2,1,0, returns delayed 10 cycles, plus a 5th read pending -> 5th read blocked until the first return; `rd_valid` sequence 0,2,1,0 carries matching data; a write from requester 1 proceeds while reads are blocked.
- `rd_data_valid` pulse with no outstanding reads -> `rd_valid`=0, `err`=1 and held until reset.
- Reset asserted during ISSUE with 2 reads outstanding -> FIFO empty and `avl_*_req`=0 the cycle after; the following 2 returns set `err`.
